// File: rtl/tlc_mon_pkg.sv
// Shared types for the traffic-light lamp safety monitor: FSM states,
// decoded per-approach lamp states and latched fault codes.
package tlc_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, TRIP} mon_state_e;

  typedef enum logic [2:0] {DARK, G, Y, R, MULTI} lamp_state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_MULTI     = 3'd2;
  localparam logic [2:0] FC_DARK      = 3'd3;
  localparam logic [2:0] FC_SEQ       = 3'd4;
  localparam logic [2:0] FC_SHORT_YLW = 3'd5;

  function automatic lamp_state_e decode_lamps(input logic grn, input logic ylw, input logic red);
    lamp_state_e ls;
    case ({grn, ylw, red})
      3'b000:  ls = DARK;
      3'b100:  ls = G;
      3'b010:  ls = Y;
      3'b001:  ls = R;
      default: ls = MULTI;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/tlc_lamp_tracker.sv
// Per-approach lamp decoder and history: last lit aspect, yellow dwell and
// dark run length; flags sequence, short-yellow and dark faults on the current sample.
module tlc_lamp_tracker
  import tlc_mon_pkg::*;
#(
  parameter int MIN_YLW  = 3,
  parameter int MAX_DARK = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        grn,
  input  logic        ylw,
  input  logic        red,
  input  logic        run_start,
  output lamp_state_e lamp_state,
  output logic        seq_err,
  output logic        short_err,
  output logic        dark_err
);

  localparam int YW = $clog2(MIN_YLW + 1);
  localparam int DW = $clog2(MAX_DARK + 2);
  localparam logic [YW-1:0] YLW_ONE  = 1;
  localparam logic [YW-1:0] YLW_SAT  = MIN_YLW[YW-1:0];
  localparam logic [DW-1:0] DARK_LIM = MAX_DARK[DW-1:0];
  localparam logic [DW-1:0] DARK_SAT = DW'(MAX_DARK + 1);

  lamp_state_e   last_lit;
  logic [YW-1:0] ylw_cnt;
  logic [DW-1:0] dark_cnt;
  logic          is_lit;

  assign lamp_state = decode_lamps(grn, ylw, red);
  assign is_lit     = (lamp_state == G) || (lamp_state == Y) || (lamp_state == R);

  always_comb begin
    seq_err = 1'b0;
    if (is_lit && (lamp_state != last_lit)) begin
      seq_err = !(((last_lit == G) && (lamp_state == Y)) ||
                  ((last_lit == Y) && (lamp_state == R)) ||
                  ((last_lit == R) && (lamp_state == G)));
    end
  end

  assign short_err = (last_lit == Y) && (lamp_state == R) && (ylw_cnt < YLW_SAT);
  // Flags on the sample that would push the run past MAX_DARK, so it trips one edge later.
  assign dark_err  = (lamp_state == DARK) && (dark_cnt >= DARK_LIM);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_lit <= R;
      ylw_cnt  <= '0;
      dark_cnt <= '0;
    end else if (run_start) begin
      last_lit <= R;
      ylw_cnt  <= '0;
      dark_cnt <= '0;
    end else begin
      if (is_lit) last_lit <= lamp_state;
      if (lamp_state == DARK) begin
        if (dark_cnt != DARK_SAT) dark_cnt <= dark_cnt + 1'b1;
      end else if (is_lit) begin
        dark_cnt <= '0;
      end
      if (lamp_state == Y) begin
        if (last_lit != Y) ylw_cnt <= YLW_ONE;
        else if (ylw_cnt != YLW_SAT) ylw_cnt <= ylw_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Lamp-side safety monitor: samples six lamps, checks signalling rules and
// latches the first fault, holding force_clr until acknowledged.
module tlc_conflict_monitor
  import tlc_mon_pkg::*;
#(
  parameter int MIN_YLW  = 3,
  parameter int MAX_DARK = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       ack,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       force_clr
);

  logic [2:0]  smp1, smp2;
  mon_state_e  state, next_state;
  logic [2:0]  code_q, det_code;
  lamp_state_e ls1, ls2;
  logic        seq1, seq2, short1, short2, dark1, dark2;
  logic        run_start, conflict;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      smp1 <= '0;
      smp2 <= '0;
    end else begin
      smp1 <= {GRN1, YLW1, RED1};
      smp2 <= {GRN2, YLW2, RED2};
    end
  end

  assign run_start = (state == IDLE) && (ls1 == R) && (ls2 == R);

  tlc_lamp_tracker #(.MIN_YLW(MIN_YLW), .MAX_DARK(MAX_DARK)) u_trk1 (
    .clock(clock), .rst_n(rst_n), .grn(smp1[2]), .ylw(smp1[1]), .red(smp1[0]),
    .run_start(run_start), .lamp_state(ls1), .seq_err(seq1), .short_err(short1), .dark_err(dark1)
  );

  tlc_lamp_tracker #(.MIN_YLW(MIN_YLW), .MAX_DARK(MAX_DARK)) u_trk2 (
    .clock(clock), .rst_n(rst_n), .grn(smp2[2]), .ylw(smp2[1]), .red(smp2[0]),
    .run_start(run_start), .lamp_state(ls2), .seq_err(seq2), .short_err(short2), .dark_err(dark2)
  );

  // Judged on raw lamps so a green/yellow lamp inside a MULTI aspect still counts as a conflict.
  assign conflict = (smp1[2] | smp1[1]) & (smp2[2] | smp2[1]);

  always_comb begin
    det_code = FC_NONE;
    if (conflict)                         det_code = FC_CONFLICT;
    else if ((ls1 == MULTI) || (ls2 == MULTI)) det_code = FC_MULTI;
    else if (state == RUN) begin
      if (dark1 || dark2)                 det_code = FC_DARK;
      else if (seq1 || seq2)              det_code = FC_SEQ;
      else if (short1 || short2)          det_code = FC_SHORT_YLW;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (det_code != FC_NONE) next_state = TRIP;
        else if (run_start)      next_state = RUN;
      end
      RUN:     if (det_code != FC_NONE) next_state = TRIP;
      TRIP:    if (ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                  code_q <= FC_NONE;
    else if (state == TRIP) begin
      if (ack)                   code_q <= FC_NONE;
    end else if (next_state == TRIP) code_q <= det_code;
  end

  always_comb begin
    fault      = (state == TRIP);
    force_clr  = (state == TRIP);
    fault_code = code_q;
  end

endmodule

// File: doc/tlc_conflict_monitor.md
# tlc_conflict_monitor

Independent safety monitor on the lamp side of the two-approach traffic-light controller. It samples the six lamp outputs (GRN1/YLW1/RED1, GRN2/YLW2/RED2), checks them against the legal signalling rules, and latches the first violation. On a violation it drives `force_clr` into the controller's CLR input until an operator acknowledges.

## Interface
- `MIN_YLW`, default 3: minimum consecutive sampled cycles an approach must show yellow before red.
- `MAX_DARK`, default 2: maximum consecutive sampled cycles an approach may show no lamp while in RUN.
- `clock  in  1` — single clock; all state updates on rising edge.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `GRN1, YLW1, RED1  in  1 each` — approach-1 lamps, active-high.
- `GRN2, YLW2, RED2  in  1 each` — approach-2 lamps, active-high.
- `ack  in  1` — fault acknowledge; single-cycle pulse.
- `fault  out  1` — high while in TRIP.
- `fault_code  out  3` — code of the latched fault; 0 when no fault.
- `force_clr  out  1` — high while in TRIP; wired to the controller's CLR.

## Operation
- Input stage: the six lamps are registered once into `smp`. All checks use `smp`. Reset value of `smp` is 0 (dark).
- Per-approach decode of `smp`:
  - exactly one lamp lit → G, Y or R;
  - none lit → DARK;
  - more than one lit → MULTI.
- Each approach tracks `last_lit`, the most recent G/Y/R. DARK samples do not change `last_lit`.
- Fault codes, listed in priority order (lowest wins on simultaneous detection):
  - 1 CONFLICT: both approaches in G or Y in the same sample.
  - 2 MULTI: either approach decodes MULTI.
  - 3 DARK: an approach is DARK for more than MAX_DARK consecutive samples.
  - 4 SEQ: an illegal lit-state change relative to `last_lit`. Legal changes are G→Y, Y→R and R→G. An unchanged state is legal.
  - 5 SHORT_YLW: a Y→R change where `ylw_cnt` < MIN_YLW.
- `ylw_cnt`, per approach:
  - set to 1 on the first Y sample;
  - +1 per subsequent Y sample, saturating at MIN_YLW;
  - DARK samples freeze it.
- `dark_cnt`, per approach: +1 per DARK sample, saturating at MAX_DARK+1; cleared on any lit sample.
- FSM:
  - IDLE (reset state): only codes 1 and 2 are checked. Go to RUN when both approaches decode R in the same sample. On entry to RUN, `last_lit` is R for both approaches and both counters are cleared.
  - RUN: all five checks are active. Any fault → TRIP, latching `fault_code`.
  - TRIP: `fault`=1, `force_clr`=1, `fault_code` held and never overwritten. `ack`=1 → IDLE, which clears `fault_code` and `fault`.
- `ack` is ignored in IDLE and RUN.
- If the fault condition persists after `ack`, IDLE re-trips for codes 1 and 2. Codes 3–5 need RUN to re-detect.

## Timing
- Reset values: `fault`=0, `fault_code`=0, `force_clr`=0, state IDLE, all counters 0, `smp`=0.
- Latency: lamps presented before edge k are captured in `smp` at edge k. A violation they cause enters TRIP at edge k+1, with outputs registered from the state.
- `ack` sampled at edge j while in TRIP: `fault`/`force_clr` deassert after edge j.
- `ack` and a new violation in the same cycle: the exit to IDLE wins. Re-detection happens from IDLE on the following sample.
- Asynchronous reset mid-TRIP: immediately returns to IDLE with outputs at reset values.
- Counter widths: `$clog2(MIN_YLW+1)` and `$clog2(MAX_DARK+2)`. No wrap-around, only saturation.

## Structure
- Package `tlc_mon_pkg`:
  - state enum {IDLE, RUN, TRIP};
  - lamp-state enum {DARK, G, Y, R, MULTI};
  - fault-code constants 0–5.
- Sub-module `tlc_lamp_tracker`, instantiated once per approach. It holds decode, `last_lit`, `ylw_cnt` and `dark_cnt`. It outputs the per-approach decoded state and seq/short/dark flags, and takes a `run_start` input that loads R and clears the counters.
- The top level holds `smp`, conflict detection, the priority encoder and the FSM.

## Test plan
- Reset, then both RED for 1 cycle → RUN. Then approach 1 G(5 cycles) → Y(3) → R, while approach 2 stays R → `fault` stays 0.
- In RUN, approach 1 G and approach 2 G in the same cycle → `fault`=1, `fault_code`=1 two edges after the lamps are applied; `force_clr`=1.
- In RUN, approach 1 Y for 2 cycles then R → `fault_code`=5. Repeat with G→R directly → `fault_code`=4.
- In RUN, approach 2 dark for 2 cycles, then R → no fault. Dark for 3 cycles → `fault_code`=3.
- YLW1 and RED1 both high (code 2) while approach 2 is G (code 1) → `fault_code`=1. Pulse `ack` with lamps still conflicting → IDLE, then TRIP again on the next sample.
- Assert `rst_n`=0 during TRIP → `fault`, `fault_code` and `force_clr` go to 0 asynchronously, state IDLE.
